// File: rtl/stage_fetch_wide_if.sv
// Fetch-stage bus bundle: iCache, branch predictor, EX redirect and instruction-buffer signals.
// FETCH_PERF_EN adds the three performance counter outputs.
interface stage_fetch_wide_if #(
  parameter int FETCH_WIDTH = 3
);
  logic                         fetch_enable_i;
  logic [FETCH_WIDTH-1:0][31:0] icache_read_addr_o;
  logic [FETCH_WIDTH-1:0]       icache_valid_i;
  logic [FETCH_WIDTH-1:0][31:0] icache_inst_i;
  logic                         bp_req_valid_o;
  logic [31:0]                  bp_req_pc_o;
  logic                         bp_req_used_o;
  logic                         bp_taken_i;
  logic [31:0]                  bp_target_i;
  logic [7:0]                   bp_ghr_i;
  logic                         ex_redirect_valid_i;
  logic [31:0]                  ex_redirect_pc_i;
  logic                         ib_valid_o;
  logic                         ib_ready_i;
  logic [FETCH_WIDTH-1:0]       ib_lane_valid_o;
  logic [FETCH_WIDTH-1:0][31:0] ib_inst_o;
  logic [FETCH_WIDTH-1:0][31:0] ib_pc_o;
  logic                         ib_pred_taken_o;
  logic [7:0]                   ib_ghr_o;
  logic                         fetch_stall_o;
  logic [31:0]                  pc_debug_o;
`ifdef FETCH_PERF_EN
  logic [31:0]                  perf_bundles_o;
  logic [31:0]                  perf_stall_cycles_o;
  logic [31:0]                  perf_redirects_o;
`endif

  modport master (
    input  fetch_enable_i, icache_valid_i, icache_inst_i, bp_taken_i, bp_target_i, bp_ghr_i,
           ex_redirect_valid_i, ex_redirect_pc_i, ib_ready_i,
    output icache_read_addr_o, bp_req_valid_o, bp_req_pc_o, bp_req_used_o, ib_valid_o,
           ib_lane_valid_o, ib_inst_o, ib_pc_o, ib_pred_taken_o, ib_ghr_o, fetch_stall_o,
           pc_debug_o
`ifdef FETCH_PERF_EN
    , output perf_bundles_o, perf_stall_cycles_o, perf_redirects_o
`endif
  );

  modport slave (
    output fetch_enable_i, icache_valid_i, icache_inst_i, bp_taken_i, bp_target_i, bp_ghr_i,
           ex_redirect_valid_i, ex_redirect_pc_i, ib_ready_i,
    input  icache_read_addr_o, bp_req_valid_o, bp_req_pc_o, bp_req_used_o, ib_valid_o,
           ib_lane_valid_o, ib_inst_o, ib_pc_o, ib_pred_taken_o, ib_ghr_o, fetch_stall_o,
           pc_debug_o
`ifdef FETCH_PERF_EN
    , input perf_bundles_o, perf_stall_cycles_o, perf_redirects_o
`endif
  );
endinterface

// File: rtl/stage_fetch_wide.sv
// N-wide fetch stage: accepts the valid lane prefix, truncates on predicted-taken, queues bundles.
// Bundle visible on ib_* one cycle after push; push stalls when queue full without a pop. FETCH_PERF_EN adds counters.
module stage_fetch_wide #(
  parameter int FETCH_WIDTH = 3,
  parameter int FQ_DEPTH    = 4
) (
  input logic               clock,
  input logic               reset,
  stage_fetch_wide_if.master fe
);
  localparam int NW = $clog2(FETCH_WIDTH + 1);
  localparam int PW = $clog2(FQ_DEPTH);
  localparam int CW = $clog2(FQ_DEPTH) + 1;

  typedef struct packed {
    logic [FETCH_WIDTH-1:0]       mask;
    logic [FETCH_WIDTH-1:0][31:0] inst;
    logic [FETCH_WIDTH-1:0][31:0] pc;
    logic                         taken;
    logic [7:0]                   ghr;
  } bundle_t;

  function automatic logic is_ctrl(input logic [31:0] w);
    return (w[6:0] == 7'b1100011) || (w[6:0] == 7'b1101111) || (w[6:0] == 7'b1100111);
  endfunction

  logic [31:0]            pc;
  logic [31:0]            next_pc;
  bundle_t                fq [FQ_DEPTH];
  logic [PW-1:0]          head, tail;
  logic [CW-1:0]          count;
  logic [NW-1:0]          n, f, keep;
  logic                   stop, f_found, taken;
  logic [FETCH_WIDTH-1:0] mask;
  logic                   full, empty, redirect, push, pop;

  always_comb begin
    n       = '0;
    stop    = 1'b0;
    f       = '0;
    f_found = 1'b0;
    mask    = '0;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      fe.icache_read_addr_o[i] = pc + (32'(i) << 2);
      if (!stop && fe.icache_valid_i[i]) n = n + NW'(1);
      else                               stop = 1'b1;
    end
    // Only lanes inside the accepted prefix may claim the predictor.
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      if (!f_found && (NW'(i) < n) && is_ctrl(fe.icache_inst_i[i])) begin
        f_found = 1'b1;
        f       = NW'(i);
      end
    end
    taken = f_found && fe.bp_taken_i;
    keep  = taken ? f + NW'(1) : n;
    for (int i = 0; i < FETCH_WIDTH; i++) mask[i] = NW'(i) < keep;
    next_pc = taken ? {fe.bp_target_i[31:2], 2'b00} : pc + (32'(n) << 2);
  end

  assign full     = (count == CW'(FQ_DEPTH));
  assign empty    = (count == '0);
  assign redirect = fe.ex_redirect_valid_i;
  assign pop      = !empty && fe.ib_ready_i && !redirect;
  assign push     = fe.fetch_enable_i && !redirect && (n != '0) && (!full || pop);

  assign fe.bp_req_valid_o  = f_found;
  assign fe.bp_req_pc_o     = pc + (32'(f) << 2);
  assign fe.bp_req_used_o   = push && f_found;
  assign fe.fetch_stall_o   = fe.fetch_enable_i && !redirect && ((n == '0) || (full && !pop));
  assign fe.pc_debug_o      = pc;

  assign fe.ib_valid_o      = !empty && !redirect;
  assign fe.ib_lane_valid_o = fq[head].mask;
  assign fe.ib_inst_o       = fq[head].inst;
  assign fe.ib_pc_o         = fq[head].pc;
  assign fe.ib_pred_taken_o = fq[head].taken;
  assign fe.ib_ghr_o        = fq[head].ghr;

  // Storage is cleared on reset so the head fields read zero while empty.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc    <= '0;
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < FQ_DEPTH; i++) fq[i] <= '0;
    end else if (redirect) begin
      pc    <= {fe.ex_redirect_pc_i[31:2], 2'b00};
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        fq[tail] <= '{mask: mask, inst: fe.icache_inst_i, pc: fe.icache_read_addr_o,
                      taken: taken, ghr: fe.bp_ghr_i};
        tail     <= tail + PW'(1);
        pc       <= next_pc;
      end
      if (pop) head <= head + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] perf_bundles, perf_stalls, perf_redirects;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      perf_bundles   <= '0;
      perf_stalls    <= '0;
      perf_redirects <= '0;
    end else begin
      if (push && perf_bundles != '1)             perf_bundles   <= perf_bundles + 32'd1;
      if (fe.fetch_stall_o && perf_stalls != '1)  perf_stalls    <= perf_stalls + 32'd1;
      if (redirect && perf_redirects != '1)       perf_redirects <= perf_redirects + 32'd1;
    end
  end

  assign fe.perf_bundles_o      = perf_bundles;
  assign fe.perf_stall_cycles_o = perf_stalls;
  assign fe.perf_redirects_o    = perf_redirects;
`endif
endmodule

// File: tb/tb_stage_fetch_wide.sv
// Directed-vector bench for stage_fetch_wide (FETCH_WIDTH=3, FQ_DEPTH=4); expected values hand-computed.
module tb_stage_fetch_wide;
  localparam logic [31:0] ADDI = 32'h0000_0013;
  localparam logic [31:0] BEQ  = 32'h0000_0063;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_vec  = 0;
  int   n_miss = 0;

  stage_fetch_wide_if #(.FETCH_WIDTH(3)) fe ();

  stage_fetch_wide #(.FETCH_WIDTH(3), .FQ_DEPTH(4)) dut (
    .clock (clock),
    .reset (reset),
    .fe    (fe)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    fe.fetch_enable_i      = 1'b0;
    fe.icache_valid_i      = 3'b000;
    fe.icache_inst_i       = {ADDI, ADDI, ADDI};
    fe.bp_taken_i          = 1'b0;
    fe.bp_target_i         = 32'h0;
    fe.bp_ghr_i            = 8'h00;
    fe.ex_redirect_valid_i = 1'b0;
    fe.ex_redirect_pc_i    = 32'h0;
    fe.ib_ready_i          = 1'b1;
    #12;
    reset = 1'b0;
    step();

    // reset state
    check_eq("rst_ib_valid", fe.ib_valid_o, 1'b0);
    check_eq("rst_pc", fe.pc_debug_o, 32'h0);
    check_eq("rst_addr2", fe.icache_read_addr_o[2], 32'h8);
    check_eq("rst_mask", fe.ib_lane_valid_o, 3'b000);

    // full 3-lane bundle of ADDI
    fe.fetch_enable_i = 1'b1;
    fe.icache_valid_i = 3'b111;
    #1;
    check_eq("addr1", fe.icache_read_addr_o[1], 32'h4);
    check_eq("stall_full_bundle", fe.fetch_stall_o, 1'b0);
    check_eq("bp_req_none", fe.bp_req_valid_o, 1'b0);
    step();
    check_eq("lat_ib_valid", fe.ib_valid_o, 1'b1);
    check_eq("lat_mask", fe.ib_lane_valid_o, 3'b111);
    check_eq("lat_pcs", fe.ib_pc_o, {32'h8, 32'h4, 32'h0});
    check_eq("next_addr0", fe.icache_read_addr_o[0], 32'hC);

    // lane 1 BEQ predicted taken at pc 0xC
    fe.icache_inst_i = {ADDI, BEQ, ADDI};
    fe.bp_taken_i    = 1'b1;
    fe.bp_target_i   = 32'h8003;
    fe.bp_ghr_i      = 8'h5A;
    #1;
    check_eq("bp_req_valid", fe.bp_req_valid_o, 1'b1);
    check_eq("bp_req_pc", fe.bp_req_pc_o, 32'h10);
    check_eq("bp_req_used", fe.bp_req_used_o, 1'b1);
    step();
    check_eq("taken_mask", fe.ib_lane_valid_o, 3'b011);
    check_eq("taken_flag", fe.ib_pred_taken_o, 1'b1);
    check_eq("taken_ghr", fe.ib_ghr_o, 8'h5A);
    check_eq("taken_pc0", fe.ib_pc_o[0], 32'hC);
    check_eq("taken_target", fe.icache_read_addr_o[0], 32'h8000);

    // hole at lane 1; BEQ beyond the hole must be ignored
    fe.icache_inst_i  = {BEQ, ADDI, ADDI};
    fe.icache_valid_i = 3'b101;
    fe.bp_ghr_i       = 8'h00;
    #1;
    check_eq("hole_no_bp", fe.bp_req_valid_o, 1'b0);
    step();
    check_eq("hole_mask", fe.ib_lane_valid_o, 3'b001);
    check_eq("hole_not_taken", fe.ib_pred_taken_o, 1'b0);
    check_eq("hole_pc_adv", fe.icache_read_addr_o[0], 32'h8004);

    // no valid lanes: stall, PC holds, queue drains
    fe.bp_taken_i     = 1'b0;
    fe.icache_inst_i  = {ADDI, ADDI, ADDI};
    fe.icache_valid_i = 3'b000;
    #1;
    check_eq("miss_stall", fe.fetch_stall_o, 1'b1);
    step();
    check_eq("miss_pc_hold", fe.icache_read_addr_o[0], 32'h8004);
    check_eq("miss_drained", fe.ib_valid_o, 1'b0);

    // fill the queue with ib_ready_i low
    fe.icache_valid_i = 3'b111;
    fe.ib_ready_i     = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      check_eq($sformatf("fill_stall_%0d", k), fe.fetch_stall_o, 1'b0);
      step();
    end
    check_eq("full_stall", fe.fetch_stall_o, 1'b1);
    check_eq("full_no_used", fe.bp_req_used_o, 1'b0);
    step();
    check_eq("full_pc_hold", fe.icache_read_addr_o[0], 32'h8034);
    check_eq("full_head_pc", fe.ib_pc_o[0], 32'h8004);
    fe.ib_ready_i = 1'b1;
    #1;
    check_eq("full_pop_no_stall", fe.fetch_stall_o, 1'b0);
    step();
    check_eq("pushpop_pc", fe.icache_read_addr_o[0], 32'h8040);
    check_eq("pushpop_head", fe.ib_pc_o[0], 32'h8010);
    fe.ib_ready_i = 1'b0;
    #1;
    check_eq("pushpop_still_full", fe.fetch_stall_o, 1'b1);

    // redirect with a full queue and a taken BEQ in lane 0
    fe.icache_inst_i       = {ADDI, ADDI, BEQ};
    fe.bp_taken_i          = 1'b1;
    fe.bp_target_i         = 32'h4444;
    fe.ex_redirect_valid_i = 1'b1;
    fe.ex_redirect_pc_i    = 32'h1236;
    #1;
    check_eq("redir_bp_valid", fe.bp_req_valid_o, 1'b1);
    check_eq("redir_used", fe.bp_req_used_o, 1'b0);
    check_eq("redir_ib_valid", fe.ib_valid_o, 1'b0);
    check_eq("redir_stall", fe.fetch_stall_o, 1'b0);
    step();
    fe.ex_redirect_valid_i = 1'b0;
    fe.fetch_enable_i      = 1'b0;
    fe.bp_taken_i          = 1'b0;
    #1;
    check_eq("redir_addr", fe.icache_read_addr_o[0], 32'h1234);
    check_eq("redir_flushed", fe.ib_valid_o, 1'b0);

    // address wrap modulo 2^32
    fe.ex_redirect_valid_i = 1'b1;
    fe.ex_redirect_pc_i    = 32'hFFFF_FFFB;
    step();
    fe.ex_redirect_valid_i = 1'b0;
    fe.fetch_enable_i      = 1'b1;
    fe.icache_inst_i       = {ADDI, ADDI, ADDI};
    fe.ib_ready_i          = 1'b1;
    #1;
    check_eq("wrap_addr1", fe.icache_read_addr_o[1], 32'hFFFF_FFFC);
    check_eq("wrap_addr2", fe.icache_read_addr_o[2], 32'h0);
    step();
    check_eq("wrap_next_pc", fe.pc_debug_o, 32'h4);
    check_eq("wrap_head_pc0", fe.ib_pc_o[0], 32'hFFFF_FFF8);

    // asynchronous reset mid-drain
    step();
    check_eq("drain_valid", fe.ib_valid_o, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    check_eq("arst_ib_valid", fe.ib_valid_o, 1'b0);
    check_eq("arst_pc", fe.pc_debug_o, 32'h0);
    check_eq("arst_mask", fe.ib_lane_valid_o, 3'b000);
    check_eq("arst_ib_pc", fe.ib_pc_o, 96'h0);
    check_eq("arst_addr2", fe.icache_read_addr_o[2], 32'h8);
`ifdef FETCH_PERF_EN
    check_eq("arst_perf_bundles", fe.perf_bundles_o, 32'h0);
    check_eq("arst_perf_stalls", fe.perf_stall_cycles_o, 32'h0);
    check_eq("arst_perf_redirects", fe.perf_redirects_o, 32'h0);
`endif
    step();
    reset = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
